uart_rx_frame_ctrl: RTL and testbench

// - Frame controller behind UART_RX. Consumes its byte strobe (o_Rx_DV/o_Rx_Byte) and hunts for a start-of-frame byte.
// - Parses the frame as [SOF][LEN][payload x LEN][CHK] and checks an XOR checksum.
// - Buffers the payload, then replays it as a valid/ready byte stream to the command decoder.
// - Reports length, checksum, inter-byte timeout and overrun errors as 1-cycle pulses.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 26 ++
 rtl/uart_rx_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART receive frame controller.
package uart_frame_pkg;

    // Frame parser states.
    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        DRAIN   = 3'd4
    } frame_state_t;

    // Default start-of-frame marker (':').
    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'h3A;

    // Running checksum step: XOR-accumulate one byte.
    function automatic logic [7:0] f_xor8(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port register array, one write port and
// one combinational read port.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port; contents need no reset, they are always written before read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: hunts for SOF, parses
// [SOF][LEN][payload][CHK], verifies the XOR checksum, then replays the
// buffered payload as a valid/ready byte stream. Errors are 1-cycle pulses.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 2610
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Pl_Valid,
    output logic [7:0] o_Pl_Data,
    output logic       o_Pl_Last,
    input  logic       i_Pl_Ready,
    output logic       o_Busy,
    output logic       o_Err_Len,
    output logic       o_Err_Chk,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overrun
);

    localparam int LW  = $clog2(MAX_LEN + 1);
    localparam int BAW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [LW-1:0] IDX_ONE   = LW'(1);
    // The counter reads TIMEOUT_CLKS-1 in the cycle whose edge would make it
    // reach TIMEOUT_CLKS; that edge is where the timeout is taken.
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    frame_state_t  state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wr_idx_q, wr_idx_d;
    logic [LW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_len_q, err_len_d;
    logic          err_chk_q, err_chk_d;
    logic          err_to_q, err_to_d;
    logic          err_ovr_q, err_ovr_d;

    logic          buf_we;
    logic [7:0]    buf_rd_data;
    logic          timing_state;
    logic          to_expire;
    logic          pl_last;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (BAW)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (buf_we),
        .wr_addr (wr_idx_q[BAW-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_idx_q[BAW-1:0]),
        .rd_data (buf_rd_data)
    );

    assign pl_last = (state_q == DRAIN) && (rd_idx_q == (len_q - IDX_ONE));

    // Next-state, datapath updates, timeout supervision and error pulses.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        chk_d     = chk_q;
        to_cnt_d  = '0;
        err_len_d = 1'b0;
        err_chk_d = 1'b0;
        err_to_d  = 1'b0;
        err_ovr_d = 1'b0;
        buf_we    = 1'b0;

        timing_state = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
        if (timing_state && !i_Rx_DV) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        // A DV in the expiry cycle wins, so expiry requires no DV.
        to_expire = timing_state && !i_Rx_DV && (to_cnt_q == TO_LAST);

        case (state_q)
            HUNT: begin
                if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte != 8'h00) && (i_Rx_Byte <= MAX_LEN_B)) begin
                        len_d    = i_Rx_Byte[LW-1:0];
                        chk_d    = i_Rx_Byte;
                        wr_idx_d = '0;
                        state_d  = PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                // SOF bytes here are plain data; no resync.
                if (i_Rx_DV) begin
                    buf_we   = 1'b1;
                    chk_d    = f_xor8(chk_q, i_Rx_Byte);
                    wr_idx_d = wr_idx_q + IDX_ONE;
                    if (wr_idx_q == (len_q - IDX_ONE)) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk_q) begin
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
            end
            DRAIN: begin
                // Incoming bytes cannot be buffered while draining.
                if (i_Rx_DV) begin
                    err_ovr_d = 1'b1;
                end
                if (i_Pl_Ready) begin
                    rd_idx_d = rd_idx_q + IDX_ONE;
                    if (pl_last) begin
                        state_d = HUNT;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (to_expire) begin
            err_to_d = 1'b1;
            state_d  = HUNT;
        end
    end

    // State and registered pulse outputs; reset aborts any frame silently.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= HUNT;
            len_q     <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            chk_q     <= '0;
            to_cnt_q  <= '0;
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            chk_q     <= chk_d;
            to_cnt_q  <= to_cnt_d;
            err_len_q <= err_len_d;
            err_chk_q <= err_chk_d;
            err_to_q  <= err_to_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    assign o_Pl_Valid    = (state_q == DRAIN);
    assign o_Pl_Data     = (state_q == DRAIN) ? buf_rd_data : 8'h00;
    assign o_Pl_Last     = pl_last;
    assign o_Busy        = (state_q != HUNT);
    assign o_Err_Len     = err_len_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Timeout = err_to_q;
    assign o_Err_Overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl. Bytes arrive as DV strobes spaced
// like a UART at 87 clks/bit; expected events are queued by the stimulus and
// popped by an independent monitor.
module tb_uart_rx_frame_ctrl;

    localparam int T_TO = 2610;
    localparam int GAP  = 870;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ready = 1'b1;

    logic       pl_valid, pl_last, busy;
    logic [7:0] pl_data;
    logic       err_len, err_chk, err_to, err_ovr;

    uart_rx_frame_ctrl dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Rx_DV       (dv),
        .i_Rx_Byte     (rx_byte),
        .o_Pl_Valid    (pl_valid),
        .o_Pl_Data     (pl_data),
        .o_Pl_Last     (pl_last),
        .i_Pl_Ready    (ready),
        .o_Busy        (busy),
        .o_Err_Len     (err_len),
        .o_Err_Chk     (err_chk),
        .o_Err_Timeout (err_to),
        .o_Err_Overrun (err_ovr)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PL = 0, EV_LEN = 1, EV_CHK = 2, EV_TO = 3, EV_OVR = 4} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        logic       last;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_dv_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input ev_kind_t k, input logic [7:0] d, input logic l);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input ev_kind_t k, input logic [7:0] d, input logic l);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d data=%h last=%0b, need none at cycle %0d", k, d, l, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_PL && (e.data != d || e.last != l))) begin
                n_err++;
                $display("FAIL event_order: got kind=%0d data=%h last=%0b, need kind=%0d data=%h last=%0b",
                         k, d, l, e.kind, e.data, e.last);
            end else begin
                $display("event kind=%0d data=%h last=%0b ok at cycle %0d", k, d, l, cyc);
            end
        end
    endtask

    // Monitor: pops expectations on every DUT event and checks stream rules.
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       stall_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (dv) last_dv_cyc = cyc;
            if (stall_prev) begin
                n_vec++;
                if (!(pl_valid && pl_data == stall_data && pl_last == stall_last)) begin
                    n_err++;
                    $display("FAIL hold_stable: got valid=%0b data=%h last=%0b, need valid=1 data=%h last=%0b",
                             pl_valid, pl_data, pl_last, stall_data, stall_last);
                end
            end
            if (err_len) check_event(EV_LEN, 8'h00, 1'b0);
            if (err_chk) check_event(EV_CHK, 8'h00, 1'b0);
            if (err_ovr) check_event(EV_OVR, 8'h00, 1'b0);
            if (err_to) begin
                check_event(EV_TO, 8'h00, 1'b0);
                n_vec++;
                if (cyc - last_dv_cyc != T_TO + 1) begin
                    n_err++;
                    $display("FAIL timeout_latency: got %0d clocks after DV edge, need %0d",
                             cyc - last_dv_cyc - 1, T_TO);
                end
            end
            if (pl_valid && ready) check_event(EV_PL, pl_data, pl_last);
            stall_prev = pl_valid && !ready;
            stall_data = pl_data;
            stall_last = pl_last;
        end
    end

    // One DV strobe, assuming we sit just after a clock edge.
    task automatic pulse(input logic [7:0] b);
        dv = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    // One byte at UART pacing.
    task automatic send(input logic [7:0] b);
        repeat (GAP - 1) @(posedge clk);
        #1;
        pulse(b);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] need);
        n_vec++;
        if (got !== need) begin
            n_err++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    // Wait (bounded) until every expected event has been seen, then idle checks.
    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("events_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("busy_idle", {31'd0, busy}, 0);
        check_val("valid_idle", {31'd0, pl_valid}, 0);
    endtask

    function automatic logic [31:0] outs_word();
        return {20'd0, pl_valid, pl_data, pl_last, busy, err_len, err_chk, err_to};
    endfunction

    logic [7:0] big [16];
    logic [7:0] big_chk;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", outs_word(), 0);
        check_val("reset_overrun", {31'd0, err_ovr}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good frame
        push_ev(EV_PL, 8'h41, 1'b0);
        push_ev(EV_PL, 8'h42, 1'b1);
        send(8'h3A); send(8'h02); send(8'h41); send(8'h42); send(8'h01);
        wait_drain(100);

        // Bad checksum, then a good frame
        push_ev(EV_CHK, 8'h00, 1'b0);
        send(8'h3A); send(8'h02); send(8'h41); send(8'h42); send(8'h00);
        wait_drain(100);
        push_ev(EV_PL, 8'h41, 1'b0);
        push_ev(EV_PL, 8'h42, 1'b1);
        send(8'h3A); send(8'h02); send(8'h41); send(8'h42); send(8'h01);
        wait_drain(100);

        // Junk, two length errors, then a good single-byte frame
        push_ev(EV_LEN, 8'h00, 1'b0);
        push_ev(EV_LEN, 8'h00, 1'b0);
        push_ev(EV_PL, 8'hC3, 1'b1);
        send(8'h55); send(8'hAA);
        send(8'h3A); send(8'h00);
        send(8'h3A); send(8'h11);
        send(8'h3A); send(8'h01); send(8'hC3); send(8'hC2);
        wait_drain(100);

        // Maximum length frame with an embedded SOF byte as data
        big_chk = 8'h10;
        for (int i = 0; i < 16; i++) begin
            big[i] = (i == 3) ? 8'h3A : 8'(i * 7 + 1);
            big_chk = big_chk ^ big[i];
            push_ev(EV_PL, big[i], (i == 15));
        end
        send(8'h3A); send(8'h10);
        for (int i = 0; i < 16; i++) send(big[i]);
        send(big_chk);
        wait_drain(100);

        // Timeout after an idle line
        push_ev(EV_TO, 8'h00, 1'b0);
        send(8'h3A); send(8'h02); send(8'h41);
        wait_drain(T_TO + 200);

        // DV exactly in the expiry cycle is processed, no timeout
        push_ev(EV_PL, 8'h41, 1'b0);
        push_ev(EV_PL, 8'h42, 1'b1);
        send(8'h3A); send(8'h02); send(8'h41);
        repeat (T_TO - 1) @(posedge clk);
        #1;
        pulse(8'h42);
        send(8'h01);
        wait_drain(100);

        // Backpressure with an overrun byte during drain
        ready = 1'b0;
        push_ev(EV_OVR, 8'h00, 1'b0);
        push_ev(EV_PL, 8'h10, 1'b0);
        push_ev(EV_PL, 8'h20, 1'b0);
        push_ev(EV_PL, 8'h30, 1'b1);
        send(8'h3A); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h03);
        send(8'h3A);
        repeat (20) @(posedge clk);
        #1;
        check_val("stalled_valid", {31'd0, pl_valid}, 1);
        check_val("stalled_data", {24'd0, pl_data}, 32'h10);
        ready = 1'b1;
        wait_drain(100);

        // Reset mid-payload aborts silently and asynchronously
        send(8'h3A); send(8'h03); send(8'h11);
        repeat (5) @(posedge clk);
        #1;
        check_val("busy_mid_frame", {31'd0, busy}, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset_outputs", outs_word(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_ev(EV_PL, 8'h7E, 1'b1);
        send(8'h3A); send(8'h01); send(8'h7E); send(8'h7F);
        wait_drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
